// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared word size and arbiter FSM state encoding.
package mem_port_arbiter_pkg;
  localparam int DEF_WORD_SIZE = 16;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_ACC   = 2'd1,
    D_ACC   = 2'd2,
    I_DRAIN = 2'd3
  } state_e;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data sides, data first.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  input  logic                 i_cancel,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  output logic                 i_stall,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 d_stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic [CNT_WIDTH-1:0] num_conflict
);
  state_e state_q, state_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic i_ready_q, i_ready_d, d_ready_q, d_ready_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    cnt_d       = (state_q == IDLE && d_req && i_req) ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d     = D_ACC;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (i_req && !i_cancel) begin
          state_d    = I_ACC;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr;
        end
      end
      D_ACC: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_ready_d = 1'b1;
          d_rdata_d = mem_we_q ? d_rdata_q : mem_rdata;
        end
      end
      I_ACC: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          i_ready_d = !i_cancel;
          i_rdata_d = i_cancel ? i_rdata_q : mem_rdata;
        end else if (i_cancel) begin
          state_d = I_DRAIN;
        end
      end
      I_DRAIN: begin
        // memory cannot abort, so the request stays up until the ack and its data is dropped
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign i_ready      = i_ready_q;
  assign d_ready      = d_ready_q;
  assign num_conflict = cnt_q;
  assign i_stall      = i_req & ~i_cancel & ~i_ready_q;
  assign d_stall      = d_req & ~d_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario checks of the fetch/data memory arbiter.
module tb_mem_port_arbiter;
  localparam int W = 16;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic reset_n, i_req, i_cancel, d_req, d_we, mem_ack;
  logic [W-1:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [W-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic i_ready, i_stall, d_ready, d_stall, mem_req, mem_we;
  logic [CW-1:0] num_conflict;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_SIZE(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel), .i_rdata(i_rdata),
    .i_ready(i_ready), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .num_conflict(num_conflict)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 0; i_req = 0; i_cancel = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; mem_ack = 0; mem_rdata = '0;
    tick(); tick();
    reset_n = 1;
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (i_ready !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got i=%b d=%b want 0 0", i_ready, d_ready); end
    checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); end
    checks++; if (num_conflict !== 8'h0 || i_rdata !== 16'h0 || d_rdata !== 16'h0) begin errors++; $display("FAIL reset_regs: got cnt=%h ird=%h drd=%h want 0", num_conflict, i_rdata, d_rdata); end
  endtask

  task automatic test_single_fetch();
    i_req = 1; i_addr = 16'h0010; #1;
    checks++; if (i_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_req: got %b want 1", i_stall); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0010 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_grant: got req=%b addr=%h we=%b want 1 0010 0", mem_req, mem_addr, mem_we); end
    tick(); tick();
    checks++; if (mem_req !== 1'b1 || i_ready !== 1'b0 || i_stall !== 1'b1) begin errors++; $display("FAIL fetch_wait: got req=%b rdy=%b stall=%b want 1 0 1", mem_req, i_ready, i_stall); end
    mem_ack = 1; mem_rdata = 16'hA5A5;
    tick();
    mem_ack = 0; #1;
    checks++; if (i_ready !== 1'b1 || i_rdata !== 16'hA5A5) begin errors++; $display("FAIL fetch_done: got rdy=%b data=%h want 1 a5a5", i_ready, i_rdata); end
    checks++; if (mem_req !== 1'b0 || i_stall !== 1'b0) begin errors++; $display("FAIL fetch_release: got req=%b stall=%b want 0 0", mem_req, i_stall); end
    i_req = 0;
    tick();
    checks++; if (i_ready !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL fetch_pulse: got rdy=%b req=%b want 0 0", i_ready, mem_req); end
  endtask

  task automatic test_simultaneous();
    i_req = 1; i_addr = 16'h0050; d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 16'h1234;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0040 || mem_wdata !== 16'h1234) begin errors++; $display("FAIL sim_data_first: got req=%b we=%b addr=%h wd=%h want 1 1 0040 1234", mem_req, mem_we, mem_addr, mem_wdata); end
    checks++; if (num_conflict !== 8'd1 || d_stall !== 1'b1 || i_stall !== 1'b1) begin errors++; $display("FAIL sim_conflict: got cnt=%0d ds=%b is=%b want 1 1 1", num_conflict, d_stall, i_stall); end
    mem_ack = 1; mem_rdata = 16'hFFFF;
    tick();
    mem_ack = 0; #1;
    checks++; if (d_ready !== 1'b1 || d_rdata !== 16'h0 || mem_req !== 1'b0 || d_stall !== 1'b0) begin errors++; $display("FAIL sim_write_done: got rdy=%b rd=%h req=%b ds=%b want 1 0000 0 0", d_ready, d_rdata, mem_req, d_stall); end
    d_req = 0;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0050 || mem_we !== 1'b0 || num_conflict !== 8'd1 || d_ready !== 1'b0) begin errors++; $display("FAIL sim_fetch_next: got req=%b addr=%h we=%b cnt=%0d drdy=%b want 1 0050 0 1 0", mem_req, mem_addr, mem_we, num_conflict, d_ready); end
    mem_ack = 1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 0; i_req = 0;
    checks++; if (i_ready !== 1'b1 || i_rdata !== 16'hBEEF) begin errors++; $display("FAIL sim_fetch_done: got rdy=%b data=%h want 1 beef", i_ready, i_rdata); end
    tick();
  endtask

  task automatic test_data_read();
    d_req = 1; d_we = 0; d_addr = 16'h0060;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0060) begin errors++; $display("FAIL read_grant: got req=%b we=%b addr=%h want 1 0 0060", mem_req, mem_we, mem_addr); end
    mem_ack = 1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 0; d_req = 0;
    checks++; if (d_ready !== 1'b1 || d_rdata !== 16'h7777) begin errors++; $display("FAIL read_done: got rdy=%b data=%h want 1 7777", d_ready, d_rdata); end
    tick();
  endtask

  task automatic test_cancel_in_flight();
    i_req = 1; i_addr = 16'h0020;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0020) begin errors++; $display("FAIL cancel_grant: got req=%b addr=%h want 1 0020", mem_req, mem_addr); end
    i_cancel = 1; #1;
    checks++; if (i_stall !== 1'b0) begin errors++; $display("FAIL cancel_stall: got %b want 0", i_stall); end
    tick();
    i_cancel = 0; i_req = 0; d_req = 1; d_we = 0; d_addr = 16'h0070; #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0020 || d_stall !== 1'b1) begin errors++; $display("FAIL drain_hold: got req=%b addr=%h ds=%b want 1 0020 1", mem_req, mem_addr, d_stall); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0020) begin errors++; $display("FAIL drain_hold2: got req=%b addr=%h want 1 0020", mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 0;
    checks++; if (mem_req !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0 || i_rdata !== 16'hBEEF) begin errors++; $display("FAIL drain_done: got req=%b irdy=%b drdy=%b ird=%h want 0 0 0 beef", mem_req, i_ready, d_ready, i_rdata); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0070 || i_ready !== 1'b0) begin errors++; $display("FAIL drain_next_data: got req=%b addr=%h irdy=%b want 1 0070 0", mem_req, mem_addr, i_ready); end
    mem_ack = 1; mem_rdata = 16'h0101;
    tick();
    mem_ack = 0; d_req = 0;
    checks++; if (d_ready !== 1'b1 || d_rdata !== 16'h0101) begin errors++; $display("FAIL drain_data_done: got rdy=%b data=%h want 1 0101", d_ready, d_rdata); end
    tick();
  endtask

  task automatic test_cancel_with_ack();
    i_req = 1; i_addr = 16'h0030;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0030) begin errors++; $display("FAIL cack_grant: got req=%b addr=%h want 1 0030", mem_req, mem_addr); end
    i_cancel = 1; mem_ack = 1; mem_rdata = 16'h9999;
    tick();
    i_cancel = 0; mem_ack = 0; i_req = 0;
    checks++; if (i_ready !== 1'b0 || i_rdata !== 16'hBEEF || mem_req !== 1'b0) begin errors++; $display("FAIL cack_done: got rdy=%b data=%h req=%b want 0 beef 0", i_ready, i_rdata, mem_req); end
    d_req = 1; d_we = 0; d_addr = 16'h00A0;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h00A0) begin errors++; $display("FAIL cack_idle: got req=%b addr=%h want 1 00a0", mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 16'h2222;
    tick();
    mem_ack = 0; d_req = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_we = 0; d_addr = 16'h0080; i_req = 1; i_addr = 16'h0090;
    tick();
    checks++; if (mem_req !== 1'b1 || num_conflict !== 8'd2) begin errors++; $display("FAIL rst_mid_pre: got req=%b cnt=%0d want 1 2", mem_req, num_conflict); end
    reset_n = 0; d_req = 0; i_req = 0;
    tick();
    reset_n = 1;
    checks++; if (mem_req !== 1'b0 || d_ready !== 1'b0 || num_conflict !== 8'd0 || mem_addr !== 16'h0) begin errors++; $display("FAIL rst_mid_clear: got req=%b rdy=%b cnt=%0d addr=%h want 0 0 0 0", mem_req, d_ready, num_conflict, mem_addr); end
    mem_ack = 1; mem_rdata = 16'h4444;
    tick();
    mem_ack = 0;
    checks++; if (d_ready !== 1'b0 || i_ready !== 1'b0 || d_rdata !== 16'h0 || mem_req !== 1'b0) begin errors++; $display("FAIL rst_stray_ack: got drdy=%b irdy=%b drd=%h req=%b want 0 0 0000 0", d_ready, i_ready, d_rdata, mem_req); end
    tick();
  endtask

  task automatic test_counter_wrap();
    i_req = 1; i_addr = 16'h0100; d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h0303; mem_ack = 1;
    tick();
    checks++; if (num_conflict !== 8'd1 || mem_req !== 1'b1) begin errors++; $display("FAIL wrap_first: got cnt=%0d req=%b want 1 1", num_conflict, mem_req); end
    tick();
    checks++; if (mem_req !== 1'b0 || d_ready !== 1'b1) begin errors++; $display("FAIL wrap_gap: got req=%b rdy=%b want 0 1", mem_req, d_ready); end
    for (int k = 0; k < 507; k++) tick();
    checks++; if (num_conflict !== 8'hFF) begin errors++; $display("FAIL wrap_max: got %h want ff", num_conflict); end
    tick(); tick();
    checks++; if (num_conflict !== 8'h00) begin errors++; $display("FAIL wrap_zero: got %h want 00", num_conflict); end
    i_req = 0; d_req = 0; mem_ack = 0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_data_read();
    test_cancel_in_flight();
    test_cancel_with_ack();
    test_reset_mid();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
